riscv_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the next-generation RISC-V core. Replaces the combinational PC-to-instruction-memory path with a registered fetch PC.
- Talks to a synchronous instruction memory with a fixed read latency of 1 cycle.
- Buffers fetched instructions with their PCs in a prefetch FIFO.
- Hands instructions to the decoder through a valid/ready handshake. A redirect input serves branches and jumps: it flushes the FIFO and restarts fetch at a new PC.

---
 rtl/riscv_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_riscv_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: registered-PC instruction fetch front end with a
// prefetch FIFO between a 1-cycle synchronous imem and the decoder.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   imem_req/addr       read request and word-aligned address
//   imem_rdata/rvalid   read response, 1 cycle after each request
//   redirect_valid/pc   flush FIFO and restart fetch at redirect_pc
//   halt                stop issuing new requests
//   inst_valid/ready    decoder handshake on the FIFO head
//   inst_data/pc        head instruction and its PC (0 when empty)
//   fifo_count          registered FIFO occupancy
module riscv_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        imem_req,
    output logic [XLEN-1:0]             imem_addr,
    input  logic [31:0]                 imem_rdata,
    input  logic                        imem_rvalid,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    input  logic                        halt,
    output logic                        inst_valid,
    input  logic                        inst_ready,
    output logic [31:0]                 inst_data,
    output logic [XLEN-1:0]             inst_pc,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [XLEN-1:0] PC_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] RST_PC  = RESET_PC & PC_MASK;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW:0]     CREDITS = (CW+1)'(FIFO_DEPTH);

    // Fetch state
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [XLEN-1:0] req_pc_q;
    logic [XLEN-1:0] req_pc_d;
    logic            inflight_q;
    logic            inflight_d;

    // FIFO state
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   rd_ptr_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic [31:0]     data_q [FIFO_DEPTH];
    logic [XLEN-1:0] pc_q   [FIFO_DEPTH];

    logic [CW:0]     credit_used;
    logic            fifo_full;
    logic            fifo_empty;
    logic            rsp_accept;
    logic            push;
    logic            pop;

    // A slot is reserved for the outstanding response, so a request only
    // issues when buffered entries plus the in-flight one leave room.
    assign credit_used = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign fifo_full   = (count_q == DEPTH_C);
    assign fifo_empty  = (count_q == '0);

    assign imem_req = rst_n
                    && !redirect_valid
                    && !halt
                    && (credit_used < CREDITS);
    assign imem_addr = fetch_pc_q;

    // Only responses to our own request are accepted; this also drops a
    // stray rvalid in the first cycle after reset (inflight is 0 then).
    assign rsp_accept = imem_rvalid && inflight_q && !redirect_valid;
    assign push       = rsp_accept && !fifo_full;
    assign pop        = !fifo_empty && inst_ready && !redirect_valid;

    // Next-state logic
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = inflight_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & PC_MASK;
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (imem_req) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                req_pc_d   = fetch_pc_q;
                inflight_d = 1'b1;
            end else if (imem_rvalid && inflight_q) begin
                inflight_d = 1'b0;
            end

            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end

            unique case (1'b1)
                push && !pop: count_d = count_q + CW'(1);
                pop && !push: count_d = count_q - CW'(1);
                default:      count_d = count_q;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RST_PC;
            req_pc_q   <= RST_PC;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only visible via count.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr_q] <= imem_rdata;
            pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    // First-word fall-through head, zeroed when empty
    assign inst_valid = !fifo_empty;
    assign inst_data  = inst_valid ? data_q[rd_ptr_q] : '0;
    assign inst_pc    = inst_valid ? pc_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;

`ifndef SYNTHESIS
    // The credit scheme makes a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(rsp_accept && fifo_full));
        end
    end
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// tb_riscv_fetch_unit: randomized scoreboard bench for riscv_fetch_unit
// with a 1-cycle imem model and a sequential-stream reference model.
module tb_riscv_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h100;
    localparam logic [31:0] XORK   = 32'hA5A5A5A5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [2:0]  fifo_count;
    logic        inject;

    int checks   = 0;
    int failures = 0;

    exp_t        exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] exp_req_pc;
    logic [31:0] reqlog [8192];
    logic [31:0] dlog   [8192];
    int          n_req = 0;
    int          n_pop = 0;
    int          cyc_n = 0;
    int          first_req_cyc = -1;
    int          first_val_cyc = -1;
    int          halt_cnt = 0;

    riscv_fetch_unit #(
        .XLEN(32),
        .RESET_PC(RST_PC),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_rvalid(imem_rvalid),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_data(inst_data),
        .inst_pc(inst_pc),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: data = addr ^ XORK, one cycle later.
    // inject forces a stray response carrying garbage.
    always @(posedge clk) begin
        imem_rvalid <= imem_req | inject;
        imem_rdata  <= inject ? 32'hDEADBEEF : (imem_addr ^ XORK);
    end

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h",
                     name, act, req);
        end
    endtask

    // Expected decoder stream: consecutive words from model_pc.
    function automatic void refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: model_pc, data: model_pc ^ XORK});
            model_pc = model_pc + 32'd4;
        end
    endfunction

    function automatic void restart(input logic [31:0] pc);
        exp_q.delete();
        model_pc   = pc & 32'hFFFF_FFFC;
        exp_req_pc = pc & 32'hFFFF_FFFC;
        refill();
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_count(input logic [2:0] target);
        for (int i = 0; i < 30; i++) begin
            if (fifo_count == target) break;
            step();
        end
        check("wait_count", 64'(fifo_count), 64'(target));
    endtask

    // Monitor / scoreboard
    initial begin
        exp_exp_init: restart(RST_PC);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                restart(RST_PC);
            end else begin
                cyc_n++;
                if (!inst_valid) begin
                    check("idle_data", 64'(inst_data), 64'h0);
                    check("idle_pc", 64'(inst_pc), 64'h0);
                end
                check("valid_vs_count", 64'(inst_valid),
                      64'(fifo_count != 3'd0));
                if (imem_req) begin
                    check("req_addr", 64'(imem_addr), 64'(exp_req_pc));
                    check("req_gate", 64'(redirect_valid | halt), 64'h0);
                    check("req_credit", 64'(fifo_count < 3'd4), 64'h1);
                    if (n_req < 8192) reqlog[n_req] = imem_addr;
                    n_req++;
                    exp_req_pc = exp_req_pc + 32'd4;
                    if (first_req_cyc < 0) first_req_cyc = cyc_n;
                end
                if (inst_valid && first_val_cyc < 0) first_val_cyc = cyc_n;
                if (inst_valid && inst_ready) begin
                    check("inst_pc", 64'(inst_pc), 64'(exp_q[0].pc));
                    check("inst_data", 64'(inst_data), 64'(exp_q[0].data));
                    void'(exp_q.pop_front());
                    refill();
                    if (n_pop < 8192) dlog[n_pop] = inst_pc;
                    n_pop++;
                end
                if (redirect_valid) restart(redirect_pc);
            end
        end
    end

    // Stimulus
    initial begin
        int base_req;
        int base_pop;
        int p0;

        rst_n          = 1'b0;
        inject         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt           = 1'b0;
        inst_ready     = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_req", 64'(imem_req), 64'h0);
        check("rst_addr", 64'(imem_addr), 64'(RST_PC));
        check("rst_valid", 64'(inst_valid), 64'h0);
        check("rst_count", 64'(fifo_count), 64'h0);

        // Stream from reset, 1 inst/cycle
        rst_n = 1'b1;
        repeat (10) step();
        check("seq0", 64'(reqlog[0]), 64'h100);
        check("seq1", 64'(reqlog[1]), 64'h104);
        check("seq2", 64'(reqlog[2]), 64'h108);
        check("latency", 64'(first_val_cyc - first_req_cyc), 64'd2);
        p0 = n_pop;
        repeat (20) step();
        check("throughput", 64'(n_pop - p0), 64'd20);

        // Redirect with 3 buffered and one response in flight
        inst_ready = 1'b0;
        wait_count(3'd3);
        check("rvalid_inflight", 64'(imem_rvalid), 64'h1);
        base_req = n_req;
        base_pop = n_pop;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2002;
        step();
        redirect_valid = 1'b0;
        check("flush_count", 64'(fifo_count), 64'h0);
        inst_ready = 1'b1;
        repeat (6) step();
        check("redir_req", 64'(reqlog[base_req]), 64'h2000);
        check("redir_first", 64'(dlog[base_pop]), 64'h2000);

        // Back-to-back redirects
        base_req = n_req;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        step();
        redirect_pc    = 32'h800;
        step();
        redirect_valid = 1'b0;
        check("b2b_noreq", 64'(n_req - base_req), 64'h0);
        base_pop = n_pop;
        repeat (6) step();
        check("b2b_req", 64'(reqlog[base_req]), 64'h800);
        check("b2b_first", 64'(dlog[base_pop]), 64'h800);

        // Halt mid-stream
        repeat (4) step();
        base_req = n_req;
        base_pop = n_pop;
        halt = 1'b1;
        repeat (5) step();
        check("halt_noreq", 64'(n_req - base_req), 64'h0);
        check("halt_drain", 64'(n_pop - base_pop), 64'd2);
        check("halt_empty", 64'(fifo_count), 64'h0);
        halt = 1'b0;
        repeat (6) step();

        // PC wrap
        base_req = n_req;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        repeat (6) step();
        check("wrap0", 64'(reqlog[base_req]), 64'hFFFF_FFF8);
        check("wrap1", 64'(reqlog[base_req+1]), 64'hFFFF_FFFC);
        check("wrap2", 64'(reqlog[base_req+2]), 64'h0);

        // Async reset with FIFO half full
        inst_ready = 1'b0;
        wait_count(3'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req", 64'(imem_req), 64'h0);
        check("arst_addr", 64'(imem_addr), 64'(RST_PC));
        check("arst_valid", 64'(inst_valid), 64'h0);
        check("arst_data", 64'(inst_data), 64'h0);
        check("arst_pc", 64'(inst_pc), 64'h0);
        check("arst_count", 64'(fifo_count), 64'h0);
        step();
        inject = 1'b1;
        step();
        rst_n  = 1'b1;
        inject = 1'b0;

        // Backpressure: stall 10 cycles, then drain in order
        base_req = n_req;
        base_pop = n_pop;
        repeat (10) step();
        check("stall_count", 64'(fifo_count), 64'd4);
        check("stall_nreq", 64'(n_req - base_req), 64'd4);
        check("stall_last", 64'(reqlog[base_req+3]), 64'h10C);
        inst_ready = 1'b1;
        repeat (8) step();
        for (int k = 0; k < 4; k++) begin
            check("drain_pc", 64'(dlog[base_pop+k]), 64'(RST_PC + 32'(4*k)));
        end
        check("resume_req", 64'(reqlog[base_req+4]), 64'h110);

        // Randomized traffic
        p0 = n_pop;
        for (int i = 0; i < 1500; i++) begin
            inst_ready = ($urandom_range(0, 9) < 7);
            if (halt_cnt > 0) halt_cnt--;
            else if ($urandom_range(0, 19) == 0)
                halt_cnt = $urandom_range(1, 6);
            halt           = (halt_cnt > 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = $urandom();
            step();
        end
        check("rand_progress", 64'(n_pop - p0 > 300), 64'h1);

        redirect_valid = 1'b0;
        halt           = 1'b0;
        inst_ready     = 1'b1;
        repeat (10) step();
        p0 = n_pop;
        repeat (10) step();
        check("final_throughput", 64'(n_pop - p0), 64'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
